// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read port (AR + R) among NUM_M masters.
// One burst in flight at a time. It counts R beats against ARLEN and keeps a sticky length-error flag.
module axi_rd_arbiter #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  // master AR
  input  logic [NUM_M-1:0]        m_arvalid,
  input  logic [NUM_M*ADDR_W-1:0] m_araddr,
  input  logic [NUM_M*LEN_W-1:0]  m_arlen,
  output logic [NUM_M-1:0]        m_arready,
  // slave AR
  output logic                    s_arvalid,
  output logic [ADDR_W-1:0]       s_araddr,
  output logic [LEN_W-1:0]        s_arlen,
  input  logic                    s_arready,
  // slave R
  input  logic                    s_rvalid,
  input  logic [DATA_W-1:0]       s_rdata,
  input  logic [1:0]              s_rresp,
  input  logic                    s_rlast,
  output logic                    s_rready,
  // master R
  output logic [NUM_M-1:0]        m_rvalid,
  output logic [DATA_W-1:0]       m_rdata,
  output logic [1:0]              m_rresp,
  output logic                    m_rlast,
  input  logic [NUM_M-1:0]        m_rready,
  // status
  output logic [NUM_M-1:0]        grant,
  output logic                    busy,
  output logic                    proto_err
);

  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_M-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   last_ptr_q, last_ptr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               proto_err_q, proto_err_d;

  logic [ADDR_W-1:0]  addr_arr [NUM_M];
  logic [LEN_W-1:0]   len_arr  [NUM_M];
  logic [IDX_W-1:0]   cand     [NUM_M];
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               ar_hs;
  logic               r_hs;

  // cand[k] is the k-th master in priority order, starting just after last_ptr
  for (genvar i = 0; i < NUM_M; i++) begin : g_unpack
    assign addr_arr[i] = m_araddr[i*ADDR_W +: ADDR_W];
    assign len_arr[i]  = m_arlen[i*LEN_W +: LEN_W];
    assign cand[i]     = IDX_W'((int'(last_ptr_q) + i + 1) % NUM_M);
  end

  // Scanning from lowest to highest priority lets the highest one overwrite.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      if (m_arvalid[cand[k]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[k];
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    last_ptr_d  = last_ptr_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    proto_err_d = proto_err_q;

    s_arvalid   = 1'b0;
    s_araddr    = '0;
    s_arlen     = '0;
    m_arready   = '0;
    s_rready    = 1'b0;
    m_rvalid    = '0;
    m_rdata     = '0;
    m_rresp     = '0;
    m_rlast     = 1'b0;
    ar_hs       = 1'b0;
    r_hs        = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          state_d           = ADDR;
        end
      end

      ADDR: begin
        s_arvalid         = m_arvalid[gidx_q];
        s_araddr          = addr_arr[gidx_q];
        s_arlen           = len_arr[gidx_q];
        m_arready[gidx_q] = s_arready;
        ar_hs             = m_arvalid[gidx_q] & s_arready;
        if (ar_hs) begin
          len_d      = len_arr[gidx_q];
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end

      DATA: begin
        s_rready         = m_rready[gidx_q];
        m_rvalid[gidx_q] = s_rvalid;
        m_rdata          = s_rdata;
        m_rresp          = s_rresp;
        m_rlast          = s_rlast;
        r_hs             = s_rvalid & m_rready[gidx_q];
        if (r_hs) begin
          if (s_rlast) begin
            // A length mismatch is flagged but the burst still ends on the real RLAST.
            if (beat_cnt_q != len_q) proto_err_d = 1'b1;
            last_ptr_d = gidx_q;
            grant_d    = '0;
            state_d    = IDLE;
          end else begin
            if (beat_cnt_q == len_q) proto_err_d = 1'b1;
            if (beat_cnt_q != '1)    beat_cnt_d  = beat_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      last_ptr_q  <= IDX_W'(NUM_M - 1);
      len_q       <= '0;
      beat_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      last_ptr_q  <= last_ptr_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q == ADDR) || (state_q == DATA);
  assign proto_err = proto_err_q;

endmodule
